// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_master
// Purpose  : AHB-Lite initiator turning burst commands (addr/size/len) into
//            AHB address and data phases, one outstanding command at a time.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int HBURST_WIDTH = 3,
  parameter int HTRANS_WIDTH = 2,
  parameter int HSIZE_WIDTH  = 3,
  parameter int HRESP_WIDTH  = 2
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [HSIZE_WIDTH-1:0]  cmd_size,
  input  logic [4:0]              cmd_len,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    rdata_valid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    done,
  output logic                    err,
  output logic                    hsel,
  output logic [ADDR_WIDTH-1:0]   haddr,
  output logic [HTRANS_WIDTH-1:0] htrans,
  output logic                    hwrite,
  output logic [HSIZE_WIDTH-1:0]  hsize,
  output logic [HBURST_WIDTH-1:0] hburst,
  output logic [DATA_WIDTH-1:0]   hwdata,
  input  logic                    hready,
  input  logic [DATA_WIDTH-1:0]   hrdata,
  input  logic [HRESP_WIDTH-1:0]  hresp
);

  localparam logic [HTRANS_WIDTH-1:0] TR_IDLE   = HTRANS_WIDTH'(0);
  localparam logic [HTRANS_WIDTH-1:0] TR_BUSY   = HTRANS_WIDTH'(1);
  localparam logic [HTRANS_WIDTH-1:0] TR_NONSEQ = HTRANS_WIDTH'(2);
  localparam logic [HTRANS_WIDTH-1:0] TR_SEQ    = HTRANS_WIDTH'(3);
  localparam logic [HRESP_WIDTH-1:0]  RESP_ERR  = HRESP_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

  state_t                  state;
  logic [4:0]              beats_left;  // beats still to issue, including current
  logic                    first;       // current beat is beat 0 (NONSEQ)
  logic                    hold_beat;   // write beat presented but stalled, data in wbuf
  logic                    dp_valid;    // a data phase is outstanding this cycle
  logic                    dp_write;
  logic [DATA_WIDTH-1:0]   wbuf;
  logic [4:0]              eff_len;
  logic [ADDR_WIDTH-1:0]   incr;
  logic                    issue;
  logic                    is_err;

  function automatic logic [HBURST_WIDTH-1:0] burst_code(input logic [4:0] len);
    case (len)
      5'd1:    return HBURST_WIDTH'(0);
      5'd4:    return HBURST_WIDTH'(3);
      5'd8:    return HBURST_WIDTH'(5);
      5'd16:   return HBURST_WIDTH'(7);
      default: return HBURST_WIDTH'(1);
    endcase
  endfunction

  assign eff_len = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
  assign incr    = ADDR_WIDTH'(1) << hsize;
  assign is_err  = (hresp == RESP_ERR);

  // A write beat may only go on the bus once its data is in hand, so the
  // transfer type reacts to wdata_valid in the same cycle; reads always issue.
  assign issue       = (state == S_ADDR) && (!hwrite || wdata_valid || hold_beat);
  assign wdata_ready = (state == S_ADDR) && hwrite && wdata_valid && !hold_beat;

  // Transfer type: NONSEQ/SEQ when issuing, IDLE/BUSY while waiting on write data
  always_comb begin
    htrans = TR_IDLE;
    if (state == S_ADDR) begin
      if (issue) htrans = first ? TR_NONSEQ : TR_SEQ;
      else       htrans = first ? TR_IDLE   : TR_BUSY;
    end
  end

  // Command FSM, address/control sequencing, data capture and completion
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      hsel        <= 1'b0;
      haddr       <= '0;
      hwrite      <= 1'b0;
      hsize       <= '0;
      hburst      <= '0;
      hwdata      <= '0;
      beats_left  <= '0;
      first       <= 1'b0;
      hold_beat   <= 1'b0;
      dp_valid    <= 1'b0;
      dp_write    <= 1'b0;
      wbuf        <= '0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      if (dp_valid && !dp_write && hready && !is_err) begin
        rdata_valid <= 1'b1;
        rdata       <= hrdata;
      end
      case (state)
        S_IDLE: begin
          // The done cycle itself still reports busy; ready returns after it.
          if (done) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            hsel       <= 1'b1;
            haddr      <= cmd_addr;
            hwrite     <= cmd_write;
            hsize      <= cmd_size;
            hburst     <= burst_code(eff_len);
            beats_left <= eff_len;
            first      <= 1'b1;
            hold_beat  <= 1'b0;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (dp_valid && is_err) begin
            dp_valid  <= 1'b0;
            hold_beat <= 1'b0;
            if (hready) begin
              state <= S_IDLE;
              hsel  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end else if (hready) begin
            dp_valid <= issue;
            dp_write <= hwrite;
            if (issue) begin
              hold_beat <= 1'b0;
              if (hwrite) hwdata <= hold_beat ? wbuf : wdata;
              if (beats_left == 5'd1) begin
                state <= S_LAST;
              end else begin
                haddr      <= haddr + incr;
                beats_left <= beats_left - 5'd1;
                first      <= 1'b0;
              end
            end
          end else if (issue && hwrite && !hold_beat) begin
            hold_beat <= 1'b1;
            wbuf      <= wdata;
          end
        end
        S_LAST: begin
          if (hready) begin
            dp_valid <= 1'b0;
            state    <= S_IDLE;
            hsel     <= 1'b0;
            done     <= 1'b1;
            err      <= is_err;
          end else if (is_err) begin
            dp_valid <= 1'b0;
            state    <= S_ERR;
          end
        end
        S_ERR: begin
          if (hready) begin
            state <= S_IDLE;
            hsel  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
